// File: rtl/ball_pattern_gen_pkg.sv
// Shared image package: default video timing, RGB565 colour constants and
// the per-axis bouncing-ball motion step used by the pattern generators.
package ball_pattern_gen_pkg;

    localparam int DEF_H_ACTIVE  = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_ACTIVE  = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam int DEF_BALL_SIZE = 16;

    localparam logic [15:0] RGB565_RED   = 16'hF800;
    localparam logic [15:0] RGB565_GREEN = 16'h07E0;
    localparam logic [15:0] RGB565_BLACK = 16'h0000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_e;

    // One axis of ball motion: top-left coordinate plus travel direction.
    typedef struct packed {
        logic [10:0] pos;
        logic        dir_neg;
    } axis_t;

    // Moves one axis by step, clamping at 0 / lim and reversing there.
    // A zero step leaves both position and direction untouched.
    function automatic axis_t axis_step(axis_t cur, logic [3:0] step, logic [10:0] lim);
        axis_t       nxt;
        logic [11:0] sum;
        nxt = cur;
        sum = {1'b0, cur.pos} + {8'd0, step};
        if (step != 4'd0) begin
            if (!cur.dir_neg) begin
                if (sum >= {1'b0, lim}) begin
                    nxt.pos     = lim;
                    nxt.dir_neg = 1'b1;
                end else begin
                    nxt.pos = sum[10:0];
                end
            end else begin
                if (cur.pos <= {7'd0, step}) begin
                    nxt.pos     = '0;
                    nxt.dir_neg = 1'b0;
                end else begin
                    nxt.pos = cur.pos - {7'd0, step};
                end
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ball_pattern_gen_if.sv
// Control and video bundle of the ball pattern generator.
interface ball_pattern_gen_if;
    import ball_pattern_gen_pkg::*;

    // No valid/ready pair: controls are level-sampled on every clock, and the
    // video side is a free-running stream without back-pressure, qualified
    // only by frame_de; all video outputs change together on the same edge.
    logic        enable;
    logic        pause;
    logic [3:0]  step_x;
    logic [3:0]  step_y;
    logic        frame_vsync;
    logic        frame_hsync;
    logic        frame_de;
    logic [15:0] frame_rgb;
    logic        frame_start;
    logic [9:0]  ball_x;
    logic [9:0]  ball_y;
    run_state_e  state_dbg;

    modport slave (
        input  enable, pause, step_x, step_y,
        output frame_vsync, frame_hsync, frame_de, frame_rgb, frame_start,
               ball_x, ball_y, state_dbg
    );

    modport master (
        output enable, pause, step_x, step_y,
        input  frame_vsync, frame_hsync, frame_de, frame_rgb, frame_start,
               ball_x, ball_y, state_dbg
    );

endinterface

// File: rtl/video_timing_gen.sv
// Raster counters and combinational region decode (de / hsync / vsync) for
// one video mode; counters sit at zero whenever run is low.
module video_timing_gen
    import ball_pattern_gen_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic [10:0] h_cnt,
    output logic [10:0] v_cnt,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_last,
    output logic        update_pt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] HA      = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] VA      = 11'(V_ACTIVE);
    localparam logic [10:0] VA_LAST = 11'(V_ACTIVE - 1);
    localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);

    logic line_last;

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (line_last) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    assign line_last  = (h_cnt == H_LAST);
    assign frame_last = line_last && (v_cnt == V_LAST);
    // Last clock of the last active line: the ball can move without tearing.
    assign update_pt  = line_last && (v_cnt == VA_LAST);

    assign de    = (h_cnt < HA) && (v_cnt < VA);
    assign hsync = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vsync = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

endmodule

// File: rtl/ball_pattern_gen.sv
// Bouncing-ball test pattern: run/idle control, per-frame ball motion and
// colour mux, with every video output registered one clock after the counters.
module ball_pattern_gen
    import ball_pattern_gen_pkg::*;
#(
    parameter int          H_ACTIVE  = DEF_H_ACTIVE,
    parameter int          H_FP      = DEF_H_FP,
    parameter int          H_SYNC    = DEF_H_SYNC,
    parameter int          H_BP      = DEF_H_BP,
    parameter int          V_ACTIVE  = DEF_V_ACTIVE,
    parameter int          V_FP      = DEF_V_FP,
    parameter int          V_SYNC    = DEF_V_SYNC,
    parameter int          V_BP      = DEF_V_BP,
    parameter int          BALL_SIZE = DEF_BALL_SIZE,
    parameter logic [15:0] BALL_RGB  = RGB565_RED,
    parameter logic [15:0] BG_RGB    = RGB565_GREEN
) (
    input logic               clk,
    input logic               rst,
    ball_pattern_gen_if.slave bus
);

    localparam logic [10:0] XMAX   = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic [10:0] YMAX   = 11'(V_ACTIVE - BALL_SIZE);
    localparam logic [10:0] BALL_W = 11'(BALL_SIZE);
    localparam logic [10:0] HALF   = 11'(BALL_SIZE / 2);

    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic        frame_last;
    logic        update_pt;

    run_state_e  state_q;
    run_state_e  state_d;
    logic        run;

    axis_t       ax_q;
    axis_t       ay_q;

    logic        frame_first;
    logic        in_ball;
    logic [15:0] rgb_d;

    logic        de_q;
    logic        hs_q;
    logic        vs_q;
    logic        start_q;
    logic [15:0] rgb_q;
    logic [9:0]  ball_x_q;
    logic [9:0]  ball_y_q;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .de         (de),
        .hsync      (hsync),
        .vsync      (vsync),
        .frame_last (frame_last),
        .update_pt  (update_pt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stopping is deferred to the frame boundary so a frame is never cut short.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.enable) state_d = ST_RUN;
            ST_RUN:  if (frame_last && !bus.enable) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign run = (state_q == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            ax_q <= '0;
            ay_q <= '0;
        end else if (run && update_pt && !bus.pause) begin
            ax_q <= axis_step(ax_q, bus.step_x, XMAX);
            ay_q <= axis_step(ay_q, bus.step_y, YMAX);
        end
    end

    always_comb begin
        frame_first = (h_cnt == 11'd0) && (v_cnt == 11'd0);
        in_ball     = (h_cnt >= ax_q.pos) && (h_cnt < ax_q.pos + BALL_W) &&
                      (v_cnt >= ay_q.pos) && (v_cnt < ay_q.pos + BALL_W);
        rgb_d       = '0;
        if (de) begin
            rgb_d = in_ball ? BALL_RGB : BG_RGB;
        end
    end

    // ball_x/ball_y latch alongside frame_start and describe the whole frame.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            de_q     <= 1'b0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            start_q  <= 1'b0;
            rgb_q    <= '0;
            ball_x_q <= '0;
            ball_y_q <= '0;
        end else begin
            de_q    <= de;
            hs_q    <= hsync;
            vs_q    <= vsync;
            start_q <= frame_first;
            rgb_q   <= rgb_d;
            if (frame_first) begin
                ball_x_q <= 10'(ax_q.pos + HALF);
                ball_y_q <= 10'(ay_q.pos + HALF);
            end
        end
    end

    assign bus.frame_de    = de_q;
    assign bus.frame_hsync = hs_q;
    assign bus.frame_vsync = vs_q;
    assign bus.frame_start = start_q;
    assign bus.frame_rgb   = rgb_q;
    assign bus.ball_x      = ball_x_q;
    assign bus.ball_y      = ball_y_q;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_ball_pattern_gen.sv
// Directed bench for ball_pattern_gen on a small 40x28 raster with a 4x4 ball.
module tb_ball_pattern_gen;
  import ball_pattern_gen_pkg::*;

  localparam int LINE  = 40;
  localparam int FRAME = 1120;
  localparam int BOUND = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errors  = 0;

  ball_pattern_gen_if bus();

  ball_pattern_gen #(
    .H_ACTIVE (32), .H_FP (2), .H_SYNC (4), .H_BP (2),
    .V_ACTIVE (24), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .BALL_SIZE (4), .BALL_RGB (16'hF800), .BG_RGB (16'h07E0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [39:0] out_word();
    return {bus.frame_vsync, bus.frame_hsync, bus.frame_de, bus.frame_start,
            bus.frame_rgb, bus.ball_x, bus.ball_y};
  endfunction

  task automatic wait_frame_start(input string tag, output int n);
    n = 0;
    while (bus.frame_start !== 1'b1 && n < BOUND) begin
      tick();
      n++;
    end
    if (n >= BOUND) begin
      vectors++;
      errors++;
      $display("FAIL %s_timeout: no frame_start within %0d clocks", tag, BOUND);
    end
  endtask

  // Entered on the frame_start sample; leaves on the sample one frame later.
  task automatic capture_frame(input string tag, input int bx, input int by, input int drop_line);
    int bad = 0;
    int first = -1;
    int de_n = 0;
    int hs_n = 0;
    int vs_n = 0;
    logic [39:0] first_got = '0;
    logic [39:0] first_exp = '0;
    logic [9:0]  got_bx = '0;
    logic [9:0]  got_by = '0;
    logic        exp_next;
    for (int c = 0; c < FRAME; c++) begin
      int line = c / LINE;
      int col  = c % LINE;
      logic e_de, e_hs, e_vs, e_st;
      logic [15:0] e_rgb;
      logic [39:0] e_word;
      logic [39:0] got;
      if (drop_line >= 0 && c == drop_line * LINE) bus.enable = 1'b0;
      e_de  = (line < 24) && (col < 32);
      e_hs  = (col >= 34) && (col <= 37);
      e_vs  = (line >= 25) && (line <= 26);
      e_st  = (c == 0);
      e_rgb = 16'h0000;
      if (e_de) begin
        if (col >= bx && col < bx + 4 && line >= by && line < by + 4) e_rgb = 16'hF800;
        else e_rgb = 16'h07E0;
      end
      e_word = {e_vs, e_hs, e_de, e_st, e_rgb, 10'(bx + 2), 10'(by + 2)};
      got = out_word();
      if (c == 0) begin
        got_bx = bus.ball_x;
        got_by = bus.ball_y;
      end
      if (got !== e_word) begin
        if (first < 0) begin
          first = c;
          first_got = got;
          first_exp = e_word;
        end
        bad++;
      end
      de_n += int'(bus.frame_de);
      hs_n += int'(bus.frame_hsync);
      vs_n += int'(bus.frame_vsync);
      tick();
    end
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_pixels: %0d bad clocks, first at line %0d col %0d got %h want %h",
               tag, bad, first / LINE, first % LINE, first_got, first_exp);
    end
    vectors++;
    if (got_bx !== 10'(bx + 2) || got_by !== 10'(by + 2)) begin
      errors++;
      $display("FAIL %s_ball_pos: got (%0d,%0d) want (%0d,%0d)", tag, got_bx, got_by, bx + 2, by + 2);
    end
    vectors++;
    if (de_n != 768) begin
      errors++;
      $display("FAIL %s_de_count: got %0d want 768", tag, de_n);
    end
    vectors++;
    if (hs_n != 112) begin
      errors++;
      $display("FAIL %s_hsync_count: got %0d want 112", tag, hs_n);
    end
    vectors++;
    if (vs_n != 80) begin
      errors++;
      $display("FAIL %s_vsync_count: got %0d want 80", tag, vs_n);
    end
    exp_next = (drop_line < 0);
    vectors++;
    if (bus.frame_start !== exp_next) begin
      errors++;
      $display("FAIL %s_frame_period: frame_start at +1120 got %b want %b", tag, bus.frame_start, exp_next);
    end
  endtask

  task automatic test_reset();
    bus.enable = 1'b0;
    bus.pause  = 1'b0;
    bus.step_x = 4'd0;
    bus.step_y = 4'd0;
    rst = 1'b1;
    repeat (3) tick();
    vectors++;
    if (out_word() !== 40'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", out_word());
    end
    vectors++;
    if (bus.state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d want %0d", bus.state_dbg, ST_IDLE);
    end
    rst = 1'b0;
    repeat (50) tick();
    vectors++;
    if (out_word() !== 40'd0 || bus.state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL idle_hold: got %h state %0d want 0 state 0", out_word(), bus.state_dbg);
    end
  endtask

  task automatic test_timing();
    int n;
    bus.step_x = 4'd3;
    bus.step_y = 4'd2;
    bus.enable = 1'b1;
    wait_frame_start("start", n);
    vectors++;
    if (n != 2) begin
      errors++;
      $display("FAIL start_latency: got %0d clocks want 2", n);
    end
    capture_frame("frame0", 0, 0, -1);
  endtask

  task automatic test_motion();
    capture_frame("frame1", 3, 2, -1);
  endtask

  task automatic test_bounce();
    int fx[13] = '{6, 9, 12, 15, 18, 21, 24, 27, 28, 25, 12, 2, 0};
    int fy[13] = '{4, 6, 8, 10, 12, 14, 16, 18, 20, 18, 3, 0, 2};
    int sx[13] = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 13, 10, 3, 1};
    int sy[13] = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 15, 3, 2, 1};
    for (int i = 0; i < 13; i++) begin
      bus.step_x = 4'(sx[i]);
      bus.step_y = 4'(sy[i]);
      capture_frame($sformatf("bounce_f%0d", i + 2), fx[i], fy[i], -1);
    end
  endtask

  task automatic test_pause();
    bus.step_x = 4'd5;
    bus.step_y = 4'd5;
    bus.pause  = 1'b1;
    for (int i = 0; i < 3; i++) capture_frame($sformatf("pause_f%0d", i), 1, 3, -1);
    bus.pause  = 1'b0;
    bus.step_x = 4'd0;
    bus.step_y = 4'd0;
    capture_frame("zero_step", 1, 3, -1);
  endtask

  task automatic test_disable();
    int noisy = 0;
    capture_frame("drop", 1, 3, 10);
    vectors++;
    if (out_word() !== 40'd0 || bus.state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL drop_idle: got %h state %0d want 0 state 0", out_word(), bus.state_dbg);
    end
    for (int c = 0; c < 1500; c++) begin
      if (out_word() !== 40'd0) noisy++;
      tick();
    end
    vectors++;
    if (noisy != 0) begin
      errors++;
      $display("FAIL drop_quiet: got %0d active clocks want 0", noisy);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bus.step_x = 4'd15;
    bus.step_y = 4'd15;
    bus.enable = 1'b1;
    wait_frame_start("restart", n);
    vectors++;
    if (n != 2) begin
      errors++;
      $display("FAIL restart_latency: got %0d clocks want 2", n);
    end
    // Two hard steps push both axes into the reverse direction.
    for (int i = 0; i < 2; i++) begin
      tick();
      wait_frame_start("advance", n);
    end
    bus.step_x = 4'd3;
    bus.step_y = 4'd2;
    repeat (5 * LINE + 10) tick();
    rst = 1'b1;
    tick();
    vectors++;
    if (out_word() !== 40'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h want 0", out_word());
    end
    vectors++;
    if (bus.state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL midreset_state: got %0d want %0d", bus.state_dbg, ST_IDLE);
    end
    tick();
    rst = 1'b0;
    wait_frame_start("reenable", n);
    vectors++;
    if (n != 2) begin
      errors++;
      $display("FAIL reenable_latency: got %0d clocks want 2", n);
    end
    capture_frame("after_reset0", 0, 0, -1);
    capture_frame("after_reset1", 3, 2, -1);
    bus.enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_timing();
    test_motion();
    test_bounce();
    test_pause();
    test_disable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ball_pattern_gen.md
BALL_PATTERN_GEN -- requirements
Module: ball_pattern_gen

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- H_ACTIVE, 640, active pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync lengths in clocks
- V_ACTIVE, 480, active lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync lengths in lines
- BALL_SIZE, 16, ball square edge in pixels
- BALL_RGB, 16'hF800, ball colour (RGB565)
- BG_RGB, 16'h07E0, background colour
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1, pixel clock (single clock domain)
- rst, in, 1, reset: synchronous, active-high
- enable, in, 1, run request
- pause, in, 1, freeze ball motion
- step_x / step_y, in, 4 each, per-frame ball displacement
- frame_vsync / frame_hsync / frame_de, out, 1 each, video timing, all active-high
- frame_rgb, out, 16, RGB565 pixel
- frame_start, out, 1, one-cycle pulse on the first active pixel of a frame
- ball_x / ball_y, out, 10 each, ball centre for the frame being output

Function
REQ-003 Timing constants SHALL be H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-004 Counters SHALL be 11 bits wide: h_cnt wraps H_TOTAL-1 -> 0 and increments v_cnt; v_cnt wraps V_TOTAL-1 -> 0.
REQ-005 The FSM SHALL have two states:
- IDLE: counters held at 0; all outputs 0.
- RUN: counters advance every clock.
REQ-006 The FSM SHALL go IDLE -> RUN on the clock after enable is sampled 1.
REQ-007 The FSM SHALL go RUN -> IDLE only at the frame boundary (h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1) with enable=0; a frame in progress always completes.
REQ-008 Region decode SHALL be:
- de when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- hsync when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
- vsync on lines V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for whole lines.
REQ-009 Every output SHALL be registered, with latency 1 clock from counter state; all outputs stay mutually aligned.
REQ-010 frame_rgb SHALL be:
- BALL_RGB when de, bx <= h_cnt < bx+BALL_SIZE, and by <= v_cnt < by+BALL_SIZE.
- otherwise BG_RGB when de.
- 0 outside de.
REQ-011 The ball position (bx, by) is its top-left corner, with ranges 0..XMAX and 0..YMAX, where XMAX = H_ACTIVE-BALL_SIZE and YMAX = V_ACTIVE-BALL_SIZE.
REQ-012 The position SHALL update once per frame, on the cycle with h_cnt=H_TOTAL-1 and v_cnt=V_ACTIVE-1, using the step_x/step_y values sampled on that cycle.
REQ-013 The X update rule SHALL be (Y is identical, using by/YMAX/step_y):
- Direction +: if bx+step_x >= XMAX then bx := XMAX and direction flips to -; else bx := bx+step_x.
- Direction -: if bx <= step_x then bx := 0 and direction flips to +; else bx := bx-step_x.
REQ-014 pause=1 or step=0 on the update cycle SHALL leave position and direction unchanged.
REQ-015 ball_x/ball_y SHALL be loaded with bx+BALL_SIZE/2 and by+BALL_SIZE/2 on the frame_start cycle and held for the whole frame.

Reset
REQ-016 rst=1 SHALL force, on the next clock, all of the following regardless of state or mid-frame position:
- FSM to IDLE and counters to 0.
- Outputs frame_vsync/hsync/de/start to 0, frame_rgb, ball_x and ball_y to 0.
- bx = by = 0, both directions +.

Structure
REQ-017 Default timing constants and the RGB565 colour constants SHALL live in the shared image package for reuse by other pattern/overlay blocks.
REQ-018 The timing counters and region decode SHALL be one sub-module, video_timing_gen; ball motion and colour muxing stay in the top.

Verification (sim params: H 32/2/4/2, V 24/1/2/1, BALL_SIZE=4)
REQ-019 Timing: reset, then enable=1 -> frame_start 2 clocks after enable is sampled; per frame:
- 32 de clocks per line, 24 de lines.
- hsync high for line clocks 34-37.
- vsync high for lines 25-26.
- line period 40, frame period 1120.
REQ-020 Motion: step_x=3, step_y=2 -> frame 0 ball pixels cols 0-3 / rows 0-3, ball_x=2, ball_y=2; frame 1 top-left (3,2), ball_x=5, ball_y=4.
REQ-021 Bounce: bx=27 dir+, step 3 -> next frame bx=28 dir-; following frame bx=25; bx=2 dir-, step 3 -> bx=0 dir+.
REQ-022 pause=1 across 3 update points -> ball_x/ball_y identical in all 4 frames.
REQ-023 enable=0 at line 10 -> lines 10-23 complete and the frame ends at the boundary; then all outputs 0 and no further frame_start.
REQ-024 rst=1 during line 5 of a moving ball -> next clock all outputs 0; after re-enable, ball at (0,0) moving +,+.
